// File: rtl/serial_comparer_pkg.sv
// Shared definitions for the serial comparer.
//   state_e        : controller states (IDLE / RUN / DONE)
//   CMP_*          : compare_select encodings
//   select_outcome : maps the final lt/eq/gt record onto the selected predicate
package serial_comparer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] CMP_NE    = 3'd0;
  localparam logic [2:0] CMP_LT    = 3'd1;
  localparam logic [2:0] CMP_LE    = 3'd2;
  localparam logic [2:0] CMP_EQ    = 3'd3;
  localparam logic [2:0] CMP_GE    = 3'd4;
  localparam logic [2:0] CMP_GT    = 3'd5;
  localparam logic [2:0] CMP_TRUE  = 3'd6;
  localparam logic [2:0] CMP_FALSE = 3'd7;

  function automatic logic select_outcome(input logic [2:0] sel, input logic lt,
                                          input logic eq, input logic gt);
    logic res;
    res = 1'b0;
    case (sel)
      CMP_NE:    res = ~eq;
      CMP_LT:    res = lt;
      CMP_LE:    res = lt | eq;
      CMP_EQ:    res = eq;
      CMP_GE:    res = gt | eq;
      CMP_GT:    res = gt;
      CMP_TRUE:  res = 1'b1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_comparer_chunk_compare.sv
// chunk_compare: purely combinational unsigned magnitude compare of one chunk.
//   a_i, b_i : CHUNK-bit operands
//   lt_o     : a_i <  b_i
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  always_comb begin
    lt_o = (a_i < b_i);
    eq_o = (a_i == b_i);
    gt_o = (a_i > b_i);
  end

endmodule

// File: rtl/serial_comparer.sv
// serial_comparer: compares A and B one CHUNK at a time, MSB chunk first, and
// reports the selected predicate as a zero-extended WIDTH-bit result.
// Assumes WIDTH % CHUNK == 0 and CHUNK >= 1.
//   clk, reset_n   : clock, asynchronous active-low reset
//   start, flush   : begin a compare / abort a running compare
//   A, B           : operands (latched when a compare is accepted)
//   signed_compare : 1 = two's complement, 0 = unsigned
//   compare_select : predicate (see CMP_* in the package)
//   busy           : compare in progress
//   done           : one-cycle pulse when S has just been updated
//   S              : result, bit 0 = outcome, upper bits zero
module serial_comparer
  import serial_comparer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_compare,
  input  logic [2:0]       compare_select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
  logic             signed_q;
  logic [2:0]       sel_q;
  logic [IDX_W-1:0] idx_q;
  logic             lt_q, gt_q, lt_d, gt_d;
  logic             accept, run_last;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             c_lt, c_eq, c_gt;

  // A flush on the same cycle always wins, so the start is simply dropped.
  assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !flush;

  // Chunk mux. Flipping both sign bits of the top chunk turns an unsigned
  // compare into a two's-complement one; lower chunks stay unsigned.
  always_comb begin
    chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    chunk_b = b_q[idx_q*CHUNK +: CHUNK];
    if (signed_q && (idx_q == IDX_LAST)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .a_i  (chunk_a),
    .b_i  (chunk_b),
    .lt_o (c_lt),
    .eq_o (c_eq),
    .gt_o (c_gt)
  );

  // The first differing chunk decides; once recorded, lower chunks are ignored.
  always_comb begin
    lt_d     = (lt_q | gt_q) ? lt_q : c_lt;
    gt_d     = (lt_q | gt_q) ? gt_q : c_gt;
    run_last = (idx_q == '0) || ((EARLY_EXIT != 0) && !c_eq);
    s_d      = WIDTH'(select_outcome(sel_q, lt_d, ~(lt_d | gt_d), gt_d));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN: begin
        if (flush)         state_d = ST_IDLE;
        else if (run_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    S    = s_q;
  end

  // Datapath: operands are frozen for the whole RUN; S only moves on the
  // cycle that completes a compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      signed_q <= 1'b0;
      sel_q    <= 3'd0;
      idx_q    <= '0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else if (accept) begin
      a_q      <= A;
      b_q      <= B;
      signed_q <= signed_compare;
      sel_q    <= compare_select;
      idx_q    <= IDX_LAST;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else if ((state_q == ST_RUN) && !flush) begin
      lt_q <= lt_d;
      gt_q <= gt_d;
      if (run_last) s_q   <= s_d;
      else          idx_q <= idx_q - 1'b1;
    end
  end

endmodule
